// File: rtl/csr_pkg.sv
// Machine-mode CSR definitions shared by the CSR block and its counters.
//   - CSR addresses
//   - csr_op (funct3) encodings
//   - mstatus / mie / mip bit positions
//   - misa value builder
package csr_pkg;

   typedef enum logic [2:0] {
      CSR_OP_RSV0 = 3'b000,
      CSR_OP_RW   = 3'b001,
      CSR_OP_RS   = 3'b010,
      CSR_OP_RC   = 3'b011,
      CSR_OP_RSV4 = 3'b100,
      CSR_OP_RWI  = 3'b101,
      CSR_OP_RSI  = 3'b110,
      CSR_OP_RCI  = 3'b111
   } csr_op_e;

   localparam logic [11:0] ADDR_MVENDORID      = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID        = 12'hF12;
   localparam logic [11:0] ADDR_MIMPID         = 12'hF13;
   localparam logic [11:0] ADDR_MHARTID        = 12'hF14;
   localparam logic [11:0] ADDR_MSTATUS        = 12'h300;
   localparam logic [11:0] ADDR_MISA           = 12'h301;
   localparam logic [11:0] ADDR_MIE            = 12'h304;
   localparam logic [11:0] ADDR_MTVEC          = 12'h305;
   localparam logic [11:0] ADDR_MCOUNTINHIBIT  = 12'h320;
   localparam logic [11:0] ADDR_MHPMEVENT3     = 12'h323;
   localparam logic [11:0] ADDR_MHPMEVENT31    = 12'h33F;
   localparam logic [11:0] ADDR_MSCRATCH       = 12'h340;
   localparam logic [11:0] ADDR_MEPC           = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE         = 12'h342;
   localparam logic [11:0] ADDR_MTVAL          = 12'h343;
   localparam logic [11:0] ADDR_MIP            = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE         = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET       = 12'hB02;
   localparam logic [11:0] ADDR_MHPMCOUNTER3   = 12'hB03;
   localparam logic [11:0] ADDR_MHPMCOUNTER31  = 12'hB1F;
   localparam logic [11:0] ADDR_MCYCLEH        = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH      = 12'hB82;
   localparam logic [11:0] ADDR_MHPMCOUNTER3H  = 12'hB83;
   localparam logic [11:0] ADDR_MHPMCOUNTER31H = 12'hB9F;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_LO   = 11;

   localparam int MIE_MSIE_BIT = 3;
   localparam int MIE_MTIE_BIT = 7;
   localparam int MIE_MEIE_BIT = 11;

   localparam int MIP_MSIP_BIT = 3;
   localparam int MIP_MTIP_BIT = 7;
   localparam int MIP_MEIP_BIT = 11;

   localparam int MISA_I_BIT = 8;

   // MXL lives in the top two bits of the register, so the value depends on width.
   function automatic logic [63:0] misa_value(input int unsigned mxlen);
      logic [63:0] v;
      v = '0;
      v[MISA_I_BIT] = 1'b1;
      if (mxlen == 64) begin
         v[63:62] = 2'd2;
      end else begin
         v[31:30] = 2'd1;
      end
      return v;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// One 64-bit event counter (mcycle / minstret style).
//   CLK      sole clock, state changes on the falling edge
//   reset_n  async active-low reset, clears the count
//   inc      count one event this cycle
//   inhibit  freeze the count
//   wr_lo    load wdata[31:0] into bits 31:0
//   wr_hi    load wdata[31:0] into bits 63:32
//   wr_full  load all 64 bits of wdata
//   count    current value
// Any write takes precedence over the increment for the whole counter.
module csr_counter (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        inc,
   input  logic        inhibit,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic        wr_full,
   input  logic [63:0] wdata,
   output logic [63:0] count
);

   always_ff @(negedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (wr_full) begin
         count <= wdata;
      end else if (wr_lo) begin
         count[31:0] <= wdata[31:0];
      end else if (wr_hi) begin
         count[63:32] <= wdata[31:0];
      end else if (inc && !inhibit) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: access decode, WARL field handling, trap entry,
// MRET, interrupt pending and the mcycle/minstret counters.
//   CLK, reset_n                  falling-edge clock, async active-low reset
//   csr_valid/addr/op             CSR instruction presented this cycle
//   rs1_data, src_field           register operand / rs1 index or zimm
//   csr_rdata, csr_illegal        old CSR value and illegal flag (combinational)
//   instret_inc                   one instruction retired
//   trap_valid/cause/pc/tval      trap entry request
//   mret                          MRET executes
//   irq_ext/timer/soft            interrupt lines
//   trap_target                   trap vector (combinational)
//   mepc_out                      current mepc
//   irq_pending                   enabled interrupt pending with MIE set
module csr_unit
   import csr_pkg::*;
#(
   parameter int unsigned      MXLEN       = 32,
   parameter logic [MXLEN-1:0] HART_ID     = '0,
   parameter logic [MXLEN-1:0] MTVEC_RESET = '0
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             csr_valid,
   input  logic [11:0]      csr_addr,
   input  logic [2:0]       csr_op,
   input  logic [MXLEN-1:0] rs1_data,
   input  logic [4:0]       src_field,
   output logic [MXLEN-1:0] csr_rdata,
   output logic             csr_illegal,
   input  logic             instret_inc,
   input  logic             trap_valid,
   input  logic [MXLEN-1:0] trap_cause,
   input  logic [MXLEN-1:0] trap_pc,
   input  logic [MXLEN-1:0] trap_tval,
   input  logic             mret,
   input  logic             irq_ext,
   input  logic             irq_timer,
   input  logic             irq_soft,
   output logic [MXLEN-1:0] trap_target,
   output logic [MXLEN-1:0] mepc_out,
   output logic             irq_pending
);

   localparam logic [63:0]      MISA_FULL = misa_value(MXLEN);
   localparam logic [MXLEN-1:0] MISA_VAL  = MISA_FULL[MXLEN-1:0];
   localparam logic [MXLEN-1:0] MIE_WMASK = MXLEN'((64'd1 << MIE_MEIE_BIT) |
                                                   (64'd1 << MIE_MTIE_BIT) |
                                                   (64'd1 << MIE_MSIE_BIT));

   logic             mstatus_mie;
   logic             mstatus_mpie;
   logic [MXLEN-1:0] mie_q;
   logic [MXLEN-1:0] mtvec_q;
   logic [MXLEN-1:0] mscratch_q;
   logic [MXLEN-1:0] mepc_q;
   logic [MXLEN-1:0] mcause_q;
   logic [MXLEN-1:0] mtval_q;
   logic             cy_inhibit;
   logic             ir_inhibit;
   logic [2:0]       irq_q;          // {ext, timer, soft}
   logic [63:0]      cycle_cnt;
   logic [63:0]      instret_cnt;

   logic [MXLEN-1:0] mstatus_val;
   logic [MXLEN-1:0] mip_val;
   logic [MXLEN-1:0] inhibit_val;
   logic [MXLEN-1:0] rd_val;
   logic             csr_impl;
   logic             wr_attempt;
   logic             op_reserved;
   logic             csr_we;
   logic [MXLEN-1:0] csr_operand;
   logic [MXLEN-1:0] csr_wdata;
   logic             wr_mstatus;
   logic [MXLEN-1:0] mtvec_base;
   logic             trap_vectored;

   // MPP is hardwired to machine mode; only MIE/MPIE are real state.
   always_comb begin
      mstatus_val = '0;
      mstatus_val[MSTATUS_MIE_BIT]                     = mstatus_mie;
      mstatus_val[MSTATUS_MPIE_BIT]                    = mstatus_mpie;
      mstatus_val[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]     = 2'b11;
   end

   always_comb begin
      mip_val = '0;
      mip_val[MIP_MEIP_BIT] = irq_q[2];
      mip_val[MIP_MTIP_BIT] = irq_q[1];
      mip_val[MIP_MSIP_BIT] = irq_q[0];
   end

   always_comb begin
      inhibit_val    = '0;
      inhibit_val[0] = cy_inhibit;
      inhibit_val[2] = ir_inhibit;
   end

   always_comb begin
      rd_val   = '0;
      csr_impl = 1'b1;
      if (csr_addr inside {[ADDR_MHPMCOUNTER3:ADDR_MHPMCOUNTER31],
                           [ADDR_MHPMEVENT3:ADDR_MHPMEVENT31]}) begin
         rd_val = '0;
      end else if (csr_addr inside {[ADDR_MHPMCOUNTER3H:ADDR_MHPMCOUNTER31H]}) begin
         csr_impl = (MXLEN == 32);
      end else begin
         case (csr_addr)
            ADDR_MVENDORID,
            ADDR_MARCHID,
            ADDR_MIMPID:        rd_val = '0;
            ADDR_MHARTID:       rd_val = HART_ID;
            ADDR_MISA:          rd_val = MISA_VAL;
            ADDR_MSTATUS:       rd_val = mstatus_val;
            ADDR_MIE:           rd_val = mie_q;
            ADDR_MIP:           rd_val = mip_val;
            ADDR_MTVEC:         rd_val = mtvec_q;
            ADDR_MCOUNTINHIBIT: rd_val = inhibit_val;
            ADDR_MSCRATCH:      rd_val = mscratch_q;
            ADDR_MEPC:          rd_val = mepc_q;
            ADDR_MCAUSE:        rd_val = mcause_q;
            ADDR_MTVAL:         rd_val = mtval_q;
            ADDR_MCYCLE:        rd_val = MXLEN'(cycle_cnt);
            ADDR_MINSTRET:      rd_val = MXLEN'(instret_cnt);
            ADDR_MCYCLEH: begin
               if (MXLEN == 32) rd_val = MXLEN'(cycle_cnt[63:32]);
               else             csr_impl = 1'b0;
            end
            ADDR_MINSTRETH: begin
               if (MXLEN == 32) rd_val = MXLEN'(instret_cnt[63:32]);
               else             csr_impl = 1'b0;
            end
            default:            csr_impl = 1'b0;
         endcase
      end
   end

   assign csr_rdata = rd_val;

   // Set/clear forms with a zero source are pure reads and may target read-only space.
   assign wr_attempt  = (csr_op[1:0] == 2'b01) || (src_field != 5'd0);
   assign op_reserved = (csr_op[1:0] == 2'b00);
   assign csr_illegal = csr_valid &
                        (~csr_impl | op_reserved | (wr_attempt & (csr_addr[11:10] == 2'b11)));
   assign csr_we      = csr_valid & ~csr_illegal & wr_attempt;

   assign csr_operand = csr_op[2] ? MXLEN'(src_field) : rs1_data;

   always_comb begin
      case (csr_op[1:0])
         2'b01:   csr_wdata = csr_operand;
         2'b10:   csr_wdata = rd_val | csr_operand;
         default: csr_wdata = rd_val & ~csr_operand;
      endcase
   end

   assign wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);

   always_ff @(negedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= MTVEC_RESET;
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
         cy_inhibit   <= 1'b0;
         ir_inhibit   <= 1'b0;
         irq_q        <= '0;
      end else begin
         irq_q <= {irq_ext, irq_timer, irq_soft};

         // Registers never touched by trap entry or MRET.
         if (csr_we) begin
            case (csr_addr)
               ADDR_MIE:      mie_q <= csr_wdata & MIE_WMASK;
               ADDR_MTVEC:    mtvec_q <= {csr_wdata[MXLEN-1:2],
                                          csr_wdata[1] ? mtvec_q[1:0] : csr_wdata[1:0]};
               ADDR_MSCRATCH: mscratch_q <= csr_wdata;
               ADDR_MCOUNTINHIBIT: begin
                  cy_inhibit <= csr_wdata[0];
                  ir_inhibit <= csr_wdata[2];
               end
               default: ;
            endcase
         end

         // Trap entry owns mepc/mcause/mtval/mstatus for the cycle; else write beats MRET.
         if (trap_valid) begin
            mepc_q       <= {trap_pc[MXLEN-1:2], 2'b00};
            mcause_q     <= trap_cause;
            mtval_q      <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else begin
            if (csr_we) begin
               case (csr_addr)
                  ADDR_MEPC:   mepc_q   <= {csr_wdata[MXLEN-1:2], 2'b00};
                  ADDR_MCAUSE: mcause_q <= csr_wdata;
                  ADDR_MTVAL:  mtval_q  <= csr_wdata;
                  default: ;
               endcase
            end
            if (wr_mstatus) begin
               mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
               mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
            end else if (mret) begin
               mstatus_mie  <= mstatus_mpie;
               mstatus_mpie <= 1'b1;
            end
         end
      end
   end

   csr_counter u_mcycle (
      .CLK     (CLK),
      .reset_n (reset_n),
      .inc     (1'b1),
      .inhibit (cy_inhibit),
      .wr_lo   (csr_we && (csr_addr == ADDR_MCYCLE) && (MXLEN == 32)),
      .wr_hi   (csr_we && (csr_addr == ADDR_MCYCLEH)),
      .wr_full (csr_we && (csr_addr == ADDR_MCYCLE) && (MXLEN == 64)),
      .wdata   (64'(csr_wdata)),
      .count   (cycle_cnt)
   );

   csr_counter u_minstret (
      .CLK     (CLK),
      .reset_n (reset_n),
      .inc     (instret_inc),
      .inhibit (ir_inhibit),
      .wr_lo   (csr_we && (csr_addr == ADDR_MINSTRET) && (MXLEN == 32)),
      .wr_hi   (csr_we && (csr_addr == ADDR_MINSTRETH)),
      .wr_full (csr_we && (csr_addr == ADDR_MINSTRET) && (MXLEN == 64)),
      .wdata   (64'(csr_wdata)),
      .count   (instret_cnt)
   );

   // Vectored mode only applies to interrupts; offset is 4 * cause without the MSB.
   assign mtvec_base    = {mtvec_q[MXLEN-1:2], 2'b00};
   assign trap_vectored = (mtvec_q[1:0] == 2'b01) && trap_cause[MXLEN-1];
   assign trap_target   = trap_vectored ?
                          mtvec_base + MXLEN'({trap_cause[MXLEN-2:0], 2'b00}) : mtvec_base;

   assign mepc_out    = mepc_q;
   assign irq_pending = mstatus_mie & (|(mip_val & mie_q));

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

   localparam int          MXLEN   = 32;
   localparam logic [31:0] HART    = 32'h0000_0005;
   localparam logic [31:0] TVEC_RS = 32'h0000_0100;
   localparam logic [2:0]  OP_RW   = 3'b001;
   localparam logic [2:0]  OP_RS   = 3'b010;

   logic        CLK;
   logic        reset_n;
   logic        csr_valid;
   logic [11:0] csr_addr;
   logic [2:0]  csr_op;
   logic [31:0] rs1_data;
   logic [4:0]  src_field;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        instret_inc;
   logic        trap_valid;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret;
   logic        irq_ext;
   logic        irq_timer;
   logic        irq_soft;
   logic [31:0] trap_target;
   logic [31:0] mepc_out;
   logic        irq_pending;

   int n_checks = 0;
   int n_errors = 0;

   csr_unit #(
      .MXLEN       (MXLEN),
      .HART_ID     (HART),
      .MTVEC_RESET (TVEC_RS)
   ) dut (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .csr_valid   (csr_valid),
      .csr_addr    (csr_addr),
      .csr_op      (csr_op),
      .rs1_data    (rs1_data),
      .src_field   (src_field),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .instret_inc (instret_inc),
      .trap_valid  (trap_valid),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .trap_tval   (trap_tval),
      .mret        (mret),
      .irq_ext     (irq_ext),
      .irq_timer   (irq_timer),
      .irq_soft    (irq_soft),
      .trap_target (trap_target),
      .mepc_out    (mepc_out),
      .irq_pending (irq_pending)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no summary, expected finish");
      $fatal(1, "time limit");
   end

   // reference model state, in architectural terms
   bit          m_mie_bit, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [2:0]  m_inh;
   logic [2:0]  m_irq;
   logic [63:0] m_cycle, m_instret;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mie_bit = 0; m_mpie = 0;
      m_mie = 0; m_mtvec = TVEC_RS; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_inh = 0; m_irq = 0;
      m_cycle = 0; m_instret = 0;
   endtask

   function automatic logic [31:0] model_mip();
      return (32'(m_irq[2]) << 11) | (32'(m_irq[1]) << 7) | (32'(m_irq[0]) << 3);
   endfunction

   task automatic model_read(input logic [11:0] a, output logic [31:0] v, output bit impl);
      impl = 1; v = 0;
      if ((a >= 12'h323 && a <= 12'h33F) || (a >= 12'hB03 && a <= 12'hB1F) ||
          (a >= 12'hB83 && a <= 12'hB9F)) begin
         v = 0;
      end else begin
         case (a)
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = HART;
            12'h300: v = 32'h1800 | (32'(m_mie_bit) << 3) | (32'(m_mpie) << 7);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h320: v = {29'b0, m_inh};
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = model_mip();
            12'hB00: v = m_cycle[31:0];
            12'hB02: v = m_instret[31:0];
            12'hB80: v = m_cycle[63:32];
            12'hB82: v = m_instret[63:32];
            default: impl = 0;
         endcase
      end
   endtask

   task automatic model_access(output logic [31:0] old_v, output bit ill, output bit wr);
      bit impl, suppressed;
      model_read(csr_addr, old_v, impl);
      suppressed = (csr_op inside {3'd2, 3'd3, 3'd6, 3'd7}) && (src_field == 0);
      ill = csr_valid && (!impl || csr_op == 3'd0 || csr_op == 3'd4 ||
                          (!suppressed && csr_addr[11:10] == 2'b11));
      wr  = csr_valid && !ill && !suppressed;
   endtask

   // Lowest priority first, so higher-priority actions overwrite shared fields.
   task automatic model_edge();
      logic [31:0] old_v, opnd, wv;
      logic [63:0] old_cycle, old_instret;
      bit ill, wr, o_mie, o_mpie;
      logic [2:0] o_inh;
      model_access(old_v, ill, wr);
      o_mie = m_mie_bit; o_mpie = m_mpie; o_inh = m_inh;
      old_cycle = m_cycle; old_instret = m_instret;
      opnd = csr_op[2] ? {27'b0, src_field} : rs1_data;
      case (csr_op[1:0])
         2'b01:   wv = opnd;
         2'b10:   wv = old_v | opnd;
         default: wv = old_v & ~opnd;
      endcase
      if (!o_inh[0]) m_cycle = m_cycle + 1;
      if (instret_inc && !o_inh[2]) m_instret = m_instret + 1;
      if (mret) begin m_mie_bit = o_mpie; m_mpie = 1; end
      if (wr) begin
         case (csr_addr)
            12'h300: begin m_mie_bit = wv[3]; m_mpie = wv[7]; end
            12'h304: m_mie = wv & 32'h888;
            12'h305: m_mtvec = wv[1] ? {wv[31:2], m_mtvec[1:0]} : wv;
            12'h320: m_inh = wv[2:0] & 3'b101;
            12'h340: m_mscratch = wv;
            12'h341: m_mepc = wv & ~32'h3;
            12'h342: m_mcause = wv;
            12'h343: m_mtval = wv;
            12'hB00: m_cycle = {old_cycle[63:32], wv};
            12'hB80: m_cycle = {wv, old_cycle[31:0]};
            12'hB02: m_instret = {old_instret[63:32], wv};
            12'hB82: m_instret = {wv, old_instret[31:0]};
            default: ;
         endcase
      end
      if (trap_valid) begin
         m_mepc = trap_pc & ~32'h3;
         m_mcause = trap_cause; m_mtval = trap_tval;
         m_mpie = o_mie; m_mie_bit = 0;
      end
      m_irq = {irq_ext, irq_timer, irq_soft};
   endtask

   task automatic settle();
      logic [31:0] v, base, tgt;
      bit ill, wr;
      #1;
      model_access(v, ill, wr);
      base = m_mtvec & ~32'h3;
      tgt  = (m_mtvec[1:0] == 2'b01 && trap_cause[31]) ?
             base + 32'd4 * (trap_cause & 32'h7FFF_FFFF) : base;
      check_val("rdata", csr_rdata, v);
      check_val("illegal", csr_illegal, ill);
      check_val("trap_target", trap_target, tgt);
      check_val("mepc_out", mepc_out, m_mepc);
      check_val("irq_pending", irq_pending, m_mie_bit && ((model_mip() & m_mie) != 0));
   endtask

   task automatic advance();
      @(negedge CLK);
      if (reset_n) model_edge();
      else         model_reset();
      @(posedge CLK);
   endtask

   task automatic set_idle();
      csr_valid = 0; csr_addr = 0; csr_op = 0; rs1_data = 0; src_field = 0;
      instret_inc = 0; trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
      mret = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0;
   endtask

   task automatic csr_cmd(input logic [11:0] a, input logic [2:0] op,
                          input logic [31:0] d, input logic [4:0] s);
      csr_valid = 1; csr_addr = a; csr_op = op; rs1_data = d; src_field = s;
   endtask

   logic [11:0] addr_pool [0:30] = '{
      12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
      12'h320, 12'h323, 12'h33F, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB03, 12'hB1F, 12'hB80, 12'hB82, 12'hB83, 12'hB9F,
      12'hC00, 12'h7C0, 12'h3A0, 12'hB01, 12'h321, 12'h322, 12'hB81
   };

   initial begin
      reset_n = 0;
      set_idle();
      irq_ext = 1; irq_timer = 1; irq_soft = 1;
      model_reset();
      repeat (2) @(posedge CLK);
      #1 check_val("rst_irq_pending", irq_pending, 0);
      @(posedge CLK);
      reset_n = 1;

      // reset values
      set_idle(); csr_cmd(12'h305, OP_RS, 0, 0);
      settle(); check_val("rst_mtvec", csr_rdata, TVEC_RS); advance();
      set_idle(); csr_cmd(12'h300, OP_RS, 0, 0);
      settle(); check_val("rst_mstatus", csr_rdata, 32'h1800); advance();

      // read-only space: pure read legal, set with nonzero source illegal
      set_idle(); csr_cmd(12'hF14, OP_RS, 0, 0);
      settle(); check_val("hartid_rd", csr_rdata, HART);
      check_val("hartid_legal", csr_illegal, 0); advance();
      set_idle(); csr_cmd(12'hF14, OP_RS, 32'hFFFF_FFFF, 1);
      settle(); check_val("hartid_wr_illegal", csr_illegal, 1); advance();

      // mcycle carry into the high half, then freeze
      set_idle(); csr_cmd(12'hB80, OP_RW, 0, 0); settle(); advance();
      set_idle(); csr_cmd(12'hB00, OP_RW, 32'hFFFF_FFFF, 0); settle(); advance();
      set_idle(); csr_cmd(12'h320, OP_RW, 1, 0); settle(); advance();
      set_idle(); csr_cmd(12'hB80, OP_RS, 0, 0);
      settle(); check_val("mcycleh_carry", csr_rdata, 1); advance();
      set_idle(); csr_cmd(12'hB00, OP_RS, 0, 0);
      settle(); check_val("mcycle_wrap", csr_rdata, 0); advance();
      set_idle(); csr_cmd(12'hB00, OP_RS, 0, 0);
      settle(); check_val("mcycle_frozen", csr_rdata, 0); advance();
      set_idle(); csr_cmd(12'h320, OP_RW, 0, 0); settle(); advance();

      // vectored trap and mret
      set_idle(); csr_cmd(12'h300, OP_RW, 32'h8, 0); settle(); advance();
      set_idle(); csr_cmd(12'h305, OP_RW, 32'h1001, 0); settle(); advance();
      set_idle(); csr_cmd(12'h300, OP_RS, 0, 0);
      trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1237; trap_tval = 32'h55;
      settle(); check_val("trap_vec_target", trap_target, 32'h101C);
      check_val("pre_trap_mstatus", csr_rdata, 32'h1808); advance();
      set_idle(); csr_cmd(12'h300, OP_RS, 0, 0);
      settle(); check_val("trap_mepc", mepc_out, 32'h1234);
      check_val("trap_mstatus", csr_rdata, 32'h1880); advance();
      set_idle(); csr_cmd(12'h300, OP_RS, 0, 0); mret = 1; settle(); advance();
      set_idle(); csr_cmd(12'h300, OP_RS, 0, 0);
      settle(); check_val("mret_mstatus", csr_rdata, 32'h1888); advance();

      // trap beats a same-cycle mepc write
      set_idle(); csr_cmd(12'h341, OP_RW, 32'h40, 0);
      trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h2000;
      settle(); advance();
      set_idle(); csr_cmd(12'h341, OP_RS, 0, 0);
      settle(); check_val("trap_vs_write_mepc", csr_rdata, 32'h2000);
      check_val("trap_vs_write_out", mepc_out, 32'h2000); advance();

      // timer interrupt pending after mip registers the line
      set_idle(); csr_cmd(12'h300, OP_RW, 32'h8, 0); settle(); advance();
      set_idle(); csr_cmd(12'h304, OP_RW, 32'h80, 0); settle(); advance();
      set_idle(); irq_timer = 1;
      settle(); check_val("irq_before_sample", irq_pending, 0); advance();
      set_idle(); irq_timer = 1;
      settle(); check_val("irq_after_sample", irq_pending, 1); advance();

      // randomized traffic against the model
      set_idle();
      for (int i = 0; i < 3000; i++) begin
         csr_valid   = ($urandom_range(0, 3) != 0);
         csr_addr    = addr_pool[$urandom_range(0, 30)];
         csr_op      = 3'($urandom_range(0, 7));
         rs1_data    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         src_field   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         instret_inc = 1'($urandom_range(0, 1));
         trap_valid  = ($urandom_range(0, 15) == 0);
         trap_cause  = ($urandom_range(0, 1) == 0) ? {1'($urandom), 27'b0, 4'($urandom)} : $urandom;
         trap_pc     = $urandom;
         trap_tval   = $urandom;
         mret        = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 7) == 0) irq_ext   = ~irq_ext;
         if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
         if ($urandom_range(0, 7) == 0) irq_soft  = ~irq_soft;
         settle();
         advance();
      end

      // reset in the middle of a write and a trap
      set_idle(); csr_cmd(12'h340, OP_RW, 32'h1111, 0); settle(); advance();
      set_idle(); csr_cmd(12'h340, OP_RW, 32'hABCD, 0);
      trap_valid = 1; trap_pc = 32'h5550; trap_cause = 32'h3;
      settle();
      #2 reset_n = 0;
      model_reset();
      @(negedge CLK);
      @(posedge CLK);
      set_idle(); csr_cmd(12'h340, OP_RS, 0, 0);
      settle(); check_val("rst_mid_mscratch", csr_rdata, 0);
      check_val("rst_mid_mepc", mepc_out, 0);
      reset_n = 1;
      advance();
      set_idle(); csr_cmd(12'h305, OP_RS, 0, 0);
      settle(); check_val("rst_mid_mtvec", csr_rdata, TVEC_RS); advance();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL take parameter MXLEN, default 32, the register width; only 32 or 64 is legal.
REQ-002 SHALL take parameter HART_ID, default 0, the constant returned by mhartid.
REQ-003 SHALL take parameter MTVEC_RESET, default 0, the reset value of mtvec.
REQ-004 CLK  in  1  sole clock; all state updates on the falling edge of CLK.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 csr_valid  in  1  a CSR instruction is presented this cycle.
REQ-007 csr_addr  in  12  CSR address.
REQ-008 csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-009 rs1_data  in  MXLEN  register source operand.
REQ-010 src_field  in  5  rs1 index, or zimm for the immediate ops.
REQ-011 csr_rdata  out  MXLEN  old CSR value (combinational).
REQ-012 csr_illegal  out  1  illegal CSR access (combinational).
REQ-013 instret_inc  in  1  one instruction retired this cycle.
REQ-014 trap_valid, trap_cause, trap_pc, trap_tval  in  1/MXLEN/MXLEN/MXLEN  trap-entry request and its data.
REQ-015 mret  in  1  MRET executes this cycle.
REQ-016 irq_ext, irq_timer, irq_soft  in  1 each  interrupt lines.
REQ-017 trap_target  out  MXLEN  trap vector address (combinational).
REQ-018 mepc_out  out  MXLEN  current mepc.
REQ-019 irq_pending  out  1  an interrupt is enabled and pending.

Function
REQ-020 Implemented CSRs SHALL be: mhartid, misa, mvendorid, marchid, mimpid, mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcountinhibit, mcycle, minstret, mhpmcounter3-31 and mhpmevent3-31; mcycleh, minstreth and mhpmcounter3h-31h SHALL exist only when MXLEN==32.
REQ-021 csr_illegal SHALL assert when csr_valid and any of these holds: the address is unimplemented, csr_op is 000 or 100, or a write reaches an address with bits[11:10]==11.
REQ-022 An illegal access SHALL leave all CSR state unchanged.
REQ-023 The write SHALL be suppressed for RS, RC, RSI and RCI when src_field==0; reads SHALL always occur.
REQ-024 The new value SHALL be: RW = operand; RS = old OR operand; RC = old AND NOT operand; the operand for the I-forms is zero-extended src_field.
REQ-025 WARL fields:
- mstatus: only MIE(3), MPIE(7) and MPP(12:11) are stored, and MPP always reads 11.
- mie: only bits 11, 7 and 3 are writable.
- mtvec: a mode write of 1x SHALL keep the old mode.
- mepc: bits[1:0] read 0.
- mhpm* and mhpmevent*: read 0 and ignore writes.
- misa: reads MXL (1 for 32, 2 for 64) and the I bit.
REQ-026 mip SHALL be read-only; bits 11, 7 and 3 SHALL equal irq_ext, irq_timer and irq_soft registered once.
REQ-027 mcycle (64 bit) SHALL increment every cycle unless mcountinhibit[0] is set; minstret SHALL increment on instret_inc unless mcountinhibit[2] is set; both SHALL wrap from all-ones to 0.
REQ-028 A CSR write to any counter half SHALL override that cycle's increment for the whole counter.
REQ-029 On trap_valid, in one edge:
- mepc <= trap_pc with bits[1:0] cleared;
- mcause <= trap_cause; mtval <= trap_tval;
- MPIE <= MIE; MIE <= 0; MPP <= 11.
REQ-030 On mret: MIE <= MPIE and MPIE <= 1.
REQ-031 Priority SHALL be trap_valid > CSR write > mret; a lower-priority update to the same field in the same cycle is dropped, and counter increments continue.
REQ-032 trap_target SHALL be mtvec base + 4*trap_cause[MXLEN-2:0] when mode==01 and trap_cause[MXLEN-1]==1, and the base otherwise.
REQ-033 irq_pending SHALL equal MIE AND OR(mip AND mie).

Reset
REQ-034 While reset_n is low, all CSRs SHALL be 0 except mtvec = MTVEC_RESET and MPP = 11; irq_pending SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abandon any in-flight write and trap.

Structure
REQ-036 Package csr_pkg SHALL hold the CSR addresses, the csr_op encodings, the mstatus/mie/mip bit positions and the misa constant.
REQ-037 A sub-module csr_counter SHALL implement one 64-bit counter with inc, inhibit, write-low, write-high and write-full controls; it is instantiated for mcycle and for minstret.

Verification
REQ-038 Reset, then read mtvec and mstatus -> MTVEC_RESET and 0x1800.
REQ-039 CSRRS to mhartid with src_field=0 -> HART_ID returned, csr_illegal=0; the same op with src_field=1 -> csr_illegal=1 and no state change.
REQ-040 mcycle at 0xFFFFFFFF (MXLEN=32) -> next cycle mcycleh=1 and mcycle=0; setting mcountinhibit=1 freezes the count.
REQ-041 trap_valid with cause 0x80000007 and mtvec 0x1001 -> trap_target 0x101C, mepc=trap_pc&~3, MIE=0, MPIE=old MIE; a following mret -> MIE restored.
REQ-042 trap_valid together with a CSRRW to mepc of 0x40 -> mepc=trap_pc and the write is dropped.
REQ-043 mie=0x80, MIE=1, irq_timer=1 -> irq_pending=1 one edge later.
